// File: rtl/pixel_scheduler_if.sv
// Handshake bundle between the frame controller, the ray-tracing cores and the pixel scheduler.
interface pixel_scheduler_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned OUT_W     = 20
);
    logic                 frame_start;
    logic [NUM_CORES-1:0] core_ready;
    logic [NUM_CORES-1:0] core_done;
    logic [NUM_CORES-1:0] core_valid;
    logic [10:0]          dispatch_h;
    logic [9:0]           dispatch_v;
    logic                 busy;
    logic                 frame_done;
    logic [OUT_W-1:0]     outstanding;

    modport master (
        output frame_start, core_ready, core_done,
        input  core_valid, dispatch_h, dispatch_v, busy, frame_done, outstanding
    );

    modport slave (
        input  frame_start, core_ready, core_done,
        output core_valid, dispatch_h, dispatch_v, busy, frame_done, outstanding
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Raster-order pixel job dispatcher with round-robin core grant and outstanding-job tracking.
// Define PIXEL_SCHED_AUTO_RESTART_EN to start the next frame straight after frame_done.
module pixel_scheduler #(
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 720,
    parameter int unsigned NUM_CORES = 4
) (
    input logic              clk,
    input logic              rst,
    pixel_scheduler_if.slave bus
);
    localparam int unsigned OUT_W  = $clog2(WIDTH * HEIGHT + 1);
    localparam int unsigned PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int          NCORES = int'(NUM_CORES);
    localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
    localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

    state_e               r_state, w_state_next;
    logic [10:0]          r_h, w_h_next;
    logic [9:0]           r_v, w_v_next;
    logic [10:0]          r_disp_h;
    logic [9:0]           r_disp_v;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_next;
    logic [OUT_W-1:0]     r_outstanding, w_out_next;
    logic [NUM_CORES-1:0] w_grant;
    logic                 w_transfer;
    int                   w_dist, w_best_dist, w_best_idx, w_done_cnt, w_out_calc;

    // Pick the ready core closest to rr_ptr going upward with wrap.
    always_comb begin
        w_dist      = 0;
        w_best_dist = NCORES;
        w_best_idx  = 0;
        for (int j = 0; j < NCORES; j++) begin
            w_dist = (j + NCORES - int'(r_rr_ptr)) % NCORES;
            if (bus.core_ready[j] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_idx  = j;
            end
        end
        w_transfer = (r_state == StDispatch) && (w_best_dist < NCORES);
        for (int j = 0; j < NCORES; j++) begin
            w_grant[j] = w_transfer && (w_best_idx == j);
        end
    end

    // Increment and completions land in the same cycle; underflow clamps at zero.
    always_comb begin
        w_done_cnt = 0;
        for (int j = 0; j < NCORES; j++) begin
            w_done_cnt = w_done_cnt + (bus.core_done[j] ? 1 : 0);
        end
        w_out_calc = int'(r_outstanding) + (w_transfer ? 1 : 0) - w_done_cnt;
        w_out_next = (w_out_calc <= 0) ? '0 : OUT_W'(w_out_calc);
    end

    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_h;
        w_v_next     = r_v;
        w_rr_next    = r_rr_ptr;
        unique case (r_state)
            StIdle: begin
                if (bus.frame_start) begin
                    w_state_next = StDispatch;
                    w_h_next     = '0;
                    w_v_next     = '0;
                end
            end
            StDispatch: begin
                if (w_transfer) begin
                    w_rr_next = PTR_W'((w_best_idx + 1) % NCORES);
                    if (r_h == H_LAST) begin
                        w_h_next = '0;
                        if (r_v == V_LAST) begin
                            w_v_next     = '0;
                            w_state_next = StDrain;
                        end else begin
                            w_v_next = r_v + 10'd1;
                        end
                    end else begin
                        w_h_next = r_h + 11'd1;
                    end
                end
            end
            StDrain: begin
                if (r_outstanding == '0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
`ifdef PIXEL_SCHED_AUTO_RESTART_EN
                w_state_next = StDispatch;
                w_h_next     = '0;
                w_v_next     = '0;
`else
                w_state_next = StIdle;
`endif
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= StIdle;
            r_h           <= '0;
            r_v           <= '0;
            r_disp_h      <= '0;
            r_disp_v      <= '0;
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_next;
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_rr_ptr      <= w_rr_next;
            r_outstanding <= w_out_next;
            if (w_transfer) begin
                r_disp_h <= r_h;
                r_disp_v <= r_v;
            end
        end
    end

    // Coordinates track the live pixel during a grant, otherwise the last one granted.
    assign bus.core_valid  = w_grant;
    assign bus.dispatch_h  = w_transfer ? r_h : r_disp_h;
    assign bus.dispatch_v  = w_transfer ? r_v : r_disp_v;
    assign bus.busy        = (r_state != StIdle);
    assign bus.frame_done  = (r_state == StDone);
    assign bus.outstanding = r_outstanding;
endmodule

// File: tb/tb_pixel_scheduler.sv
// Randomized bench for pixel_scheduler against a raster/round-robin reference model.
module tb_pixel_scheduler;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int          NC = 2;
    localparam int unsigned OW = $clog2(W * H + 1);
`ifdef PIXEL_SCHED_AUTO_RESTART_EN
    localparam bit AutoRestart = 1'b1;
`else
    localparam bit AutoRestart = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_scheduler_if #(.NUM_CORES(NC), .OUT_W(OW)) bus ();

    pixel_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Stimulus for the next cycle
    logic          t_rst;
    logic          t_start;
    logic [NC-1:0] t_ready;

    // Reference model: 0 idle, 1 dispatching, 2 draining, 3 frame done
    int            m_phase, m_pix, m_ptr, m_out, m_last_h, m_last_v;
    int            cyc, lat, fd_seen, dut_grants;
    logic [NC-1:0] sched [64];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit do_chk);
        int idx, c, nout;
        logic [NC-1:0] ev;
        @(negedge clk);
        rst             = t_rst;
        bus.frame_start = t_start;
        bus.core_ready  = t_ready;
        bus.core_done   = sched[cyc % 64];
        sched[cyc % 64] = '0;
        #1;
        idx = -1;
        if (m_phase == 1) begin
            for (int k = 0; k < NC; k++) begin
                c = (m_ptr + k) % NC;
                if (idx < 0 && ((t_ready >> c) & 1) != 0) idx = c;
            end
        end
        ev = (idx >= 0) ? NC'(1 << idx) : '0;
        if (do_chk) begin
            check_val("core_valid", 32'(bus.core_valid), 32'(ev));
            check_val("dispatch_h", 32'(bus.dispatch_h), (idx >= 0) ? m_pix % W : m_last_h);
            check_val("dispatch_v", 32'(bus.dispatch_v), (idx >= 0) ? m_pix / W : m_last_v);
            check_val("busy", 32'(bus.busy), (m_phase != 0) ? 1 : 0);
            check_val("frame_done", 32'(bus.frame_done), (m_phase == 3) ? 1 : 0);
            check_val("outstanding", 32'(bus.outstanding), m_out);
        end
        if (bus.frame_done === 1'b1) fd_seen++;
        if (t_rst === 1'b1 && bus.core_valid !== '0) dut_grants++;
        if (!t_rst) begin
            m_phase = 0; m_pix = 0; m_ptr = 0; m_out = 0; m_last_h = 0; m_last_v = 0;
        end else begin
            nout = m_out + ((idx >= 0) ? 1 : 0) - $countones(bus.core_done);
            if (nout < 0) nout = 0;
            case (m_phase)
                0: if (t_start) begin m_phase = 1; m_pix = 0; end
                1: if (idx >= 0) begin
                    m_ptr    = (idx + 1) % NC;
                    m_last_h = m_pix % W;
                    m_last_v = m_pix / W;
                    m_pix++;
                    sched[(cyc + lat) % 64] = sched[(cyc + lat) % 64] | NC'(1 << idx);
                    if (m_pix == W * H) m_phase = 2;
                end
                2: if (m_out == 0) m_phase = 3;
                default: begin m_phase = AutoRestart ? 1 : 0; m_pix = 0; end
            endcase
            m_out = nout;
        end
        cyc++;
    endtask

    function automatic logic [NC-1:0] ready_pat(input int mode, input int k);
        case (mode)
            0: return 2'b11;
            1: return 2'b10;
            2: return (k >= 3 && k < 8) ? 2'b00 : 2'b11;
            default: return NC'($urandom_range(0, 3));
        endcase
    endfunction

    // mode: 0 all ready, 1 core 1 only, 2 five-cycle stall, 3 random; abort_after>0 resets mid-frame
    task automatic run_frame(input int mode, input int lat_i, input int abort_after);
        int k;
        bit fin;
        lat        = lat_i;
        fd_seen    = 0;
        dut_grants = 0;
        t_start    = 1'b1;
        t_ready    = ready_pat(mode, 0);
        step(1'b1);
        t_start = 1'b0;
        k   = 0;
        fin = 1'b0;
        while (!fin && k < 200) begin
            t_ready = ready_pat(mode, k);
            if (mode == 3) t_start = ($urandom_range(0, 3) == 0);
            if (abort_after > 0 && dut_grants == abort_after) t_rst = 1'b0;
            fin = (t_rst == 1'b0) || (m_phase == 3);
            step(1'b1);
            k++;
        end
        t_rst   = 1'b1;
        t_start = 1'b0;
        check_val("frame_in_budget", 32'(fin), 1);
        check_val("grant_count", dut_grants, (abort_after > 0) ? abort_after : W * H);
        check_val("frame_done_pulses", fd_seen, (abort_after > 0) ? 0 : 1);
    endtask

    task automatic post_frame();
        t_ready = 2'b11;
        t_start = 1'b0;
        repeat (4) step(1'b1);
        t_rst = 1'b0;
        step(1'b1);
        t_rst = 1'b1;
        repeat (7) step(1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sched[i] = '0;
        m_phase = 0; m_pix = 0; m_ptr = 0; m_out = 0; m_last_h = 0; m_last_v = 0;
        cyc = 0; lat = 3; fd_seen = 0; dut_grants = 0;
        t_rst = 1'b0; t_start = 1'b0; t_ready = '0;
        step(1'b0);
        step(1'b1);
        t_start = 1'b1;
        step(1'b1);
        t_rst   = 1'b1;
        t_start = 1'b0;
        step(1'b1);
        run_frame(0, 3, 0); post_frame();
        run_frame(1, 3, 0); post_frame();
        run_frame(2, 3, 0); post_frame();
        run_frame(0, 1, 0); post_frame();
        run_frame(0, 3, 3); post_frame();
        repeat (8) begin
            run_frame(3, int'($urandom_range(1, 5)), 0);
            post_frame();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720, frame height in pixels.
REQ-003 SHALL have parameter NUM_CORES, default 4, number of ray-tracing cores served (1..8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-low reset.
REQ-006 SHALL have port frame_start  input  1  single-cycle request to render one frame.
REQ-007 SHALL have port core_ready  input  NUM_CORES  core i can accept a pixel job this cycle.
REQ-008 SHALL have port core_done  input  NUM_CORES  core i finished one pixel this cycle (ray_done).
REQ-009 SHALL have port core_valid  output  NUM_CORES  one-hot dispatch grant; job transfers when asserted.
REQ-010 SHALL have port dispatch_h  output  11  pixel column of the current job.
REQ-011 SHALL have port dispatch_v  output  10  pixel row of the current job.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port frame_done  output  1  single-cycle pulse when the frame is complete.
REQ-014 SHALL have port outstanding  output  $clog2(WIDTH*HEIGHT+1)  jobs dispatched but not yet completed.

Function
REQ-015 SHALL implement FSM states IDLE, DISPATCH, DRAIN, DONE.
REQ-016 IDLE SHALL go to DISPATCH on frame_start=1 and load pixel counters h=0, v=0; frame_start in any other state SHALL be ignored.
REQ-017 In DISPATCH, core_valid SHALL be combinational: one-hot bit of the first core with core_ready=1, searching upward (with wrap) from rr_ptr; all zero if no core is ready.
REQ-018 When core_valid is nonzero, dispatch_h/dispatch_v SHALL present the current (h,v), and the transfer SHALL complete in that cycle.
REQ-019 On transfer, rr_ptr SHALL become (granted index + 1) mod NUM_CORES; h SHALL increment, wrapping from WIDTH-1 to 0 with v incremented.
REQ-020 The transfer of pixel (WIDTH-1, HEIGHT-1) SHALL move the FSM to DRAIN; no further grants in that frame.
REQ-021 core_valid SHALL be zero in IDLE, DRAIN and DONE.
REQ-022 outstanding SHALL increment by 1 per transfer and decrement by popcount(core_done) per cycle, both applied in the same cycle; a decrement below zero SHALL saturate at 0.
REQ-023 DRAIN SHALL go to DONE in the cycle after outstanding reads 0 (covers a final dispatch and a completion in the same cycle).
REQ-024 DONE SHALL assert frame_done for exactly one cycle, then go to IDLE (see REQ-030).
REQ-025 First possible grant SHALL be the cycle after frame_start is sampled; throughput SHALL be 1 job per cycle while any core is ready.
REQ-026 dispatch_h/dispatch_v SHALL hold their last value when no grant is made.

Reset
REQ-027 On rst=0 at a clock edge: state=IDLE, h=0, v=0, rr_ptr=0, outstanding=0, frame_done=0, busy=0, core_valid=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse; core_done pulses arriving after reset SHALL saturate outstanding at 0.
REQ-029 Reset SHALL take priority over frame_start and core_done in the same cycle.

Configuration
REQ-030 With macro PIXEL_SCHED_AUTO_RESTART_EN defined, DONE SHALL go directly to DISPATCH with h=0, v=0 (continuous frames, busy stays 1); without it, DONE SHALL go to IDLE and wait for frame_start.

Verification
REQ-031 WIDTH=4, HEIGHT=2, NUM_CORES=2, core_ready=2'b11, each core_done 3 cycles after its grant, frame_start pulse -> 8 grants alternating 01,10,01,...; (h,v) sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); frame_done one cycle after outstanding returns to 0.
REQ-032 Same config, core_ready=2'b10 constant -> every grant to core 1, same raster order, rr_ptr wraps to 0 each time.
REQ-033 core_ready=0 for 5 cycles mid-frame -> core_valid=0, dispatch_h/v held, outstanding unchanged except for completions.
REQ-034 Final grant and a core_done in the same cycle -> outstanding unchanged that cycle; frame_done only after it reaches 0.
REQ-035 rst=0 after 3 grants -> next cycle all outputs at reset values, no frame_done; late core_done keeps outstanding at 0.
REQ-036 PIXEL_SCHED_AUTO_RESTART_EN defined -> after frame_done, next grant is (0,0) without frame_start; undefined -> busy=0 and no grant until frame_start.
